// File: rtl/memory_stage.sv
// Memory stage: loads, stores and a word stack in data memory.
// Two-word push/pop run as two-cycle sequences through a small FSM.
module memory_stage #(
  parameter logic [15:0] SP_INIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [2:0]  op,
  input  logic [15:0] alu_result,
  input  logic [15:0] write_data,
  input  logic [31:0] ctx_in,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic        ctx_valid,
  output logic [31:0] ctx_out,
  output logic [15:0] sp_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PUSH2_LO = 2'd1,
    POP2_HI  = 2'd2
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_PUSH  = 3'b011;
  localparam logic [2:0] OP_POP   = 3'b100;
  localparam logic [2:0] OP_PUSH2 = 3'b101;
  localparam logic [2:0] OP_POP2  = 3'b110;

  state_t      state_q, state_d;
  logic [15:0] sp_q, sp_d;
  logic [15:0] lo_q, lo_d;
  logic        wbv_q, wbv_d;
  logic        ctxv_q, ctxv_d;
  logic        accept;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign accept    = ex_valid && in_ready;
  assign sp_out    = sp_q;
  assign wb_valid  = wbv_q;
  assign ctx_valid = ctxv_q;
  assign wb_data   = wbv_q ? mem_rdata : 16'h0000;
  assign ctx_out   = ctxv_q ? {mem_rdata, lo_q} : 32'h0;

  // Next state, SP update and memory strobes for the current cycle.
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    lo_d      = lo_q;
    wbv_d     = 1'b0;
    ctxv_d    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (op)
            OP_LOAD: begin
              mem_re   = 1'b1;
              mem_addr = alu_result;
              wbv_d    = 1'b1;
            end
            OP_STORE: begin
              mem_we    = 1'b1;
              mem_addr  = alu_result;
              mem_wdata = write_data;
            end
            OP_PUSH: begin
              mem_we    = 1'b1;
              mem_addr  = sp_q;
              mem_wdata = write_data;
              sp_d      = sp_q - 16'd1;
            end
            OP_POP: begin
              mem_re   = 1'b1;
              mem_addr = sp_q + 16'd1;
              sp_d     = sp_q + 16'd1;
              wbv_d    = 1'b1;
            end
            OP_PUSH2: begin
              mem_we    = 1'b1;
              mem_addr  = sp_q;
              mem_wdata = ctx_in[31:16];
              lo_d      = ctx_in[15:0];
              state_d   = PUSH2_LO;
            end
            OP_POP2: begin
              mem_re   = 1'b1;
              mem_addr = sp_q + 16'd1;
              state_d  = POP2_HI;
            end
            default: ;
          endcase
        end
      end
      PUSH2_LO: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q - 16'd1;
        mem_wdata = lo_q;
        sp_d      = sp_q - 16'd2;
        state_d   = IDLE;
      end
      POP2_HI: begin
        lo_d     = mem_rdata;
        mem_re   = 1'b1;
        mem_addr = sp_q + 16'd2;
        sp_d     = sp_q + 16'd2;
        ctxv_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  // State registers; reset aborts any two-cycle sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sp_q    <= SP_INIT;
      lo_q    <= 16'h0000;
      wbv_q   <= 1'b0;
      ctxv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      lo_q    <= lo_d;
      wbv_q   <= wbv_d;
      ctxv_q  <= ctxv_d;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: reset/table vectors, directed stack
// sequences and a randomized run against a stack/memory model.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] alu_result = 16'h0;
  logic [15:0] write_data = 16'h0;
  logic [31:0] ctx_in = 32'h0;
  logic        in_ready;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_we, mem_re;
  logic [15:0] mem_rdata;
  logic        wb_valid, ctx_valid;
  logic [15:0] wb_data, sp_out;
  logic [31:0] ctx_out;

  int checks = 0;
  int errors = 0;

  memory_stage #(.SP_INIT(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .op(op),
    .alu_result(alu_result), .write_data(write_data),
    .ctx_in(ctx_in), .in_ready(in_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .ctx_valid(ctx_valid), .ctx_out(ctx_out), .sp_out(sp_out)
  );

  always #5 clk = ~clk;

  bit [15:0] ram [0:65535];
  bit [15:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic drv(input bit ev, input logic [2:0] o,
                     input logic [15:0] a, input logic [15:0] d,
                     input logic [31:0] c);
    @(negedge clk);
    reset = 1'b0;
    ex_valid = ev;
    op = o;
    alu_result = a;
    write_data = d;
    ctx_in = c;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ex_valid = 1'b1;
    op = 3'b011;
    alu_result = 16'h0;
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_re", mem_re, 0);
  endtask

  typedef struct {
    bit ev; logic [2:0] op; logic [15:0] a; logic [15:0] d;
    logic [31:0] c; bit we; bit re; logic [15:0] addr;
    logic [15:0] wd; logic [15:0] sp_nx; bit rdy_nx;
  } vec_t;
  vec_t vec [9];

  typedef struct {
    bit we; bit re; logic [15:0] addr; logic [15:0] wd;
    bit wbv; logic [15:0] wbd; bit ctxv; logic [31:0] ctxd; bit rdy;
  } exp_t;
  exp_t sched [4];
  logic [15:0] sp_ref;
  logic [15:0] pend;
  bit busy;
  int cyc;

  task automatic clr(input int i);
    sched[i] = '{default: 0};
    sched[i].rdy = 1'b1;
  endtask

  task automatic rand_cycle();
    int s, s1, s2;
    bit ev, was_busy;
    logic [2:0] o;
    logic [15:0] a, d, t1, t2, sp_nx;
    logic [31:0] c;
    s = cyc % 4; s1 = (cyc + 1) % 4; s2 = (cyc + 2) % 4;
    o = 3'($urandom_range(0, 7));
    ev = ($urandom_range(0, 7) != 0);
    a = 16'($urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0) a = sp_ref + 16'($urandom_range(0, 3));
    d = 16'($urandom);
    c = $urandom;
    was_busy = busy;
    sp_nx = sp_ref;
    t1 = sp_ref + 16'd1;
    t2 = sp_ref + 16'd2;
    if (!was_busy && ev) begin
      case (o)
        3'd1: begin
          sched[s].re = 1; sched[s].addr = a;
          sched[s1].wbv = 1; sched[s1].wbd = ref_mem[a];
        end
        3'd2: begin
          sched[s].we = 1; sched[s].addr = a; sched[s].wd = d;
          ref_mem[a] = d;
        end
        3'd3: begin
          sched[s].we = 1; sched[s].addr = sp_ref; sched[s].wd = d;
          ref_mem[sp_ref] = d;
          sp_nx = sp_ref - 16'd1;
        end
        3'd4: begin
          sched[s].re = 1; sched[s].addr = t1;
          sched[s1].wbv = 1; sched[s1].wbd = ref_mem[t1];
          sp_nx = t1;
        end
        3'd5: begin
          sched[s].we = 1; sched[s].addr = sp_ref;
          sched[s].wd = c[31:16];
          sched[s1].we = 1; sched[s1].addr = sp_ref - 16'd1;
          sched[s1].wd = c[15:0]; sched[s1].rdy = 0;
          ref_mem[sp_ref] = c[31:16];
          ref_mem[sp_ref - 16'd1] = c[15:0];
          pend = 16'hFFFE; busy = 1;
        end
        3'd6: begin
          sched[s].re = 1; sched[s].addr = t1;
          sched[s1].re = 1; sched[s1].addr = t2; sched[s1].rdy = 0;
          sched[s2].ctxv = 1;
          sched[s2].ctxd = {ref_mem[t2], ref_mem[t1]};
          pend = 16'd2; busy = 1;
        end
        default: ;
      endcase
    end
    drv(ev, o, a, d, c);
    chk("r_rdy", in_ready, sched[s].rdy);
    chk("r_we", mem_we, sched[s].we);
    chk("r_re", mem_re, sched[s].re);
    if (sched[s].we || sched[s].re) chk("r_addr", mem_addr, sched[s].addr);
    if (sched[s].we) chk("r_wdata", mem_wdata, sched[s].wd);
    chk("r_wbv", wb_valid, sched[s].wbv);
    if (sched[s].wbv) chk("r_wbd", wb_data, sched[s].wbd);
    chk("r_ctxv", ctx_valid, sched[s].ctxv);
    if (sched[s].ctxv) chk("r_ctxd", ctx_out, sched[s].ctxd);
    chk("r_sp", sp_out, sp_ref);
    clr(s);
    if (was_busy) begin
      sp_ref = sp_ref + pend;
      busy = 0;
    end else begin
      sp_ref = sp_nx;
    end
    cyc++;
  endtask

  initial begin
    logic [15:0] prior;
    vec[0] = '{1, 3'd1, 16'h0042, 16'h0, 32'h0,
               0, 1, 16'h0042, 16'h0, 16'hFFFF, 1};
    vec[1] = '{1, 3'd2, 16'h0077, 16'hBEEF, 32'h0,
               1, 0, 16'h0077, 16'hBEEF, 16'hFFFF, 1};
    vec[2] = '{1, 3'd3, 16'h0, 16'h1357, 32'h0,
               1, 0, 16'hFFFF, 16'h1357, 16'hFFFE, 1};
    vec[3] = '{1, 3'd4, 16'h0, 16'h0, 32'h0,
               0, 1, 16'h0000, 16'h0, 16'h0000, 1};
    vec[4] = '{1, 3'd5, 16'h0, 16'h0, 32'h12345678,
               1, 0, 16'hFFFF, 16'h1234, 16'hFFFF, 0};
    vec[5] = '{1, 3'd6, 16'h0, 16'h0, 32'h0,
               0, 1, 16'h0000, 16'h0, 16'hFFFF, 0};
    vec[6] = '{1, 3'd0, 16'h0010, 16'h1, 32'h0,
               0, 0, 16'h0, 16'h0, 16'hFFFF, 1};
    vec[7] = '{1, 3'd7, 16'h0010, 16'h1, 32'h1,
               0, 0, 16'h0, 16'h0, 16'hFFFF, 1};
    vec[8] = '{0, 3'd3, 16'h0010, 16'h1, 32'h1,
               0, 0, 16'h0, 16'h0, 16'hFFFF, 1};

    do_reset();
    drv(0, 3'd0, 16'h0, 16'h0, 32'h0);
    chk("rst_sp", sp_out, 16'hFFFF);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_ctxv", ctx_valid, 0);
    chk("rst_wbd", wb_data, 0);
    chk("rst_ctxo", ctx_out, 0);
    chk("rst_rdy", in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      drv(vec[i].ev, vec[i].op, vec[i].a, vec[i].d, vec[i].c);
      chk($sformatf("v%0d_we", i), mem_we, vec[i].we);
      chk($sformatf("v%0d_re", i), mem_re, vec[i].re);
      if (vec[i].we || vec[i].re)
        chk($sformatf("v%0d_addr", i), mem_addr, vec[i].addr);
      if (vec[i].we)
        chk($sformatf("v%0d_wd", i), mem_wdata, vec[i].wd);
      drv(0, 3'd0, 16'h0, 16'h0, 32'h0);
      chk($sformatf("v%0d_sp", i), sp_out, vec[i].sp_nx);
      chk($sformatf("v%0d_rdy", i), in_ready, vec[i].rdy_nx);
    end

    do_reset();
    drv(1, 3'd3, 16'h0, 16'h1234, 32'h0);
    chk("pp_we", mem_we, 1);
    chk("pp_addr", mem_addr, 16'hFFFF);
    chk("pp_wd", mem_wdata, 16'h1234);
    drv(1, 3'd4, 16'h0, 16'h0, 32'h0);
    chk("pp_sp1", sp_out, 16'hFFFE);
    chk("pp_re", mem_re, 1);
    chk("pp_raddr", mem_addr, 16'hFFFF);
    drv(0, 3'd0, 16'h0, 16'h0, 32'h0);
    chk("pp_wbv", wb_valid, 1);
    chk("pp_wbd", wb_data, 16'h1234);
    chk("pp_sp2", sp_out, 16'hFFFF);

    do_reset();
    drv(1, 3'd5, 16'h0, 16'h0, 32'hAABBCCDD);
    chk("p2_we0", mem_we, 1);
    chk("p2_a0", mem_addr, 16'hFFFF);
    chk("p2_d0", mem_wdata, 16'hAABB);
    drv(1, 3'd1, 16'h0003, 16'h0, 32'h0);
    chk("p2_rdy1", in_ready, 0);
    chk("p2_we1", mem_we, 1);
    chk("p2_re1", mem_re, 0);
    chk("p2_a1", mem_addr, 16'hFFFE);
    chk("p2_d1", mem_wdata, 16'hCCDD);
    drv(1, 3'd6, 16'h0, 16'h0, 32'h0);
    chk("p2_rdy2", in_ready, 1);
    chk("p2_sp2", sp_out, 16'hFFFD);
    chk("q2_re0", mem_re, 1);
    chk("q2_a0", mem_addr, 16'hFFFE);
    drv(1, 3'd2, 16'h0005, 16'h9999, 32'h0);
    chk("q2_rdy1", in_ready, 0);
    chk("q2_we1", mem_we, 0);
    chk("q2_re1", mem_re, 1);
    chk("q2_a1", mem_addr, 16'hFFFF);
    drv(0, 3'd0, 16'h0, 16'h0, 32'h0);
    chk("q2_ctxv", ctx_valid, 1);
    chk("q2_ctxo", ctx_out, 32'hAABBCCDD);
    chk("q2_wbv", wb_valid, 0);
    chk("q2_sp", sp_out, 16'hFFFF);

    drv(1, 3'd2, 16'h0010, 16'h00FF, 32'h0);
    chk("sl_we", mem_we, 1);
    chk("sl_a0", mem_addr, 16'h0010);
    chk("sl_rdy0", in_ready, 1);
    drv(1, 3'd1, 16'h0010, 16'h0, 32'h0);
    chk("sl_re", mem_re, 1);
    chk("sl_rdy1", in_ready, 1);
    drv(0, 3'd0, 16'h0, 16'h0, 32'h0);
    chk("sl_wbv", wb_valid, 1);
    chk("sl_wbd", wb_data, 16'h00FF);
    chk("sl_rdy2", in_ready, 1);

    do_reset();
    drv(1, 3'd4, 16'h0, 16'h0, 32'h0);
    drv(1, 3'd3, 16'h0, 16'h5555, 32'h0);
    chk("wr_sp0", sp_out, 16'h0000);
    chk("wr_a0", mem_addr, 16'h0000);
    chk("wr_d0", mem_wdata, 16'h5555);
    drv(1, 3'd4, 16'h0, 16'h0, 32'h0);
    chk("wr_sp1", sp_out, 16'hFFFF);
    chk("wr_a1", mem_addr, 16'h0000);
    drv(0, 3'd0, 16'h0, 16'h0, 32'h0);
    chk("wr_sp2", sp_out, 16'h0000);
    chk("wr_wbd", wb_data, 16'h5555);

    do_reset();
    drv(1, 3'd3, 16'h0, 16'h4321, 32'h0);
    drv(1, 3'd6, 16'h0, 16'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    ex_valid = 1'b1;
    op = 3'b001;
    #1;
    chk("ar_we", mem_we, 0);
    chk("ar_re", mem_re, 0);
    drv(0, 3'd0, 16'h0, 16'h0, 32'h0);
    chk("ar_ctxv", ctx_valid, 0);
    chk("ar_sp", sp_out, 16'hFFFF);
    chk("ar_rdy", in_ready, 1);
    drv(0, 3'd0, 16'h0, 16'h0, 32'h0);
    chk("ar_ctxv2", ctx_valid, 0);

    prior = ram[16'hFFFE];
    do_reset();
    drv(1, 3'd5, 16'h0, 16'h0, 32'h11112222);
    @(negedge clk);
    reset = 1'b1;
    ex_valid = 1'b0;
    #1;
    chk("al_we", mem_we, 0);
    drv(0, 3'd0, 16'h0, 16'h0, 32'h0);
    chk("al_sp", sp_out, 16'hFFFF);
    chk("al_mem", ram[16'hFFFE], prior);

    drv(1, 3'd7, 16'h0020, 16'h7777, 32'h7);
    chk("rs_we", mem_we, 0);
    chk("rs_re", mem_re, 0);
    chk("rs_rdy0", in_ready, 1);
    drv(0, 3'd0, 16'h0, 16'h0, 32'h0);
    chk("rs_sp", sp_out, 16'hFFFF);
    chk("rs_rdy1", in_ready, 1);

    do_reset();
    for (int i = 0; i < 65536; i++) ref_mem[i] = ram[i];
    for (int i = 0; i < 4; i++) clr(i);
    sp_ref = 16'hFFFF;
    busy = 0;
    pend = 16'h0;
    cyc = 0;
    for (int i = 0; i < 3000; i++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter SP_INIT, default 16'hFFFF: stack pointer value after reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 ex_valid  in  1  operation from execute stage present.
REQ-005 op  in  3  operation code: 000 none, 001 load, 010 store, 011 push, 100 pop, 101 push2, 110 pop2, 111 reserved.
REQ-006 alu_result  in  16  load/store word address.
REQ-007 write_data  in  16  store/push data.
REQ-008 ctx_in  in  32  push2 data, where [31:16] is the high word.
REQ-009 in_ready  out  1  operation accepted this cycle when ex_valid=1 and in_ready=1.
REQ-010 mem_addr  out  16  data memory word address.
REQ-011 mem_wdata  out  16  data memory write data.
REQ-012 mem_we  out  1  data memory write strobe.
REQ-013 mem_re  out  1  data memory read strobe.
REQ-014 mem_rdata  in  16  synchronous RAM read data, valid the cycle after mem_re.
REQ-015 wb_valid  out  1  one-cycle pulse; wb_data holds a load/pop result.
REQ-016 wb_data  out  16  load/pop result.
REQ-017 ctx_valid  out  1  one-cycle pulse; ctx_out holds a pop2 result.
REQ-018 ctx_out  out  32  pop2 result, where [31:16] is the high word.
REQ-019 sp_out  out  16  current stack pointer.

Function
REQ-020 FSM states SHALL be IDLE, PUSH2_LO, POP2_HI; in_ready SHALL be 1 only in IDLE.
REQ-021 Memory strobes, address and write data SHALL be combinational from the accepted inputs in the accept cycle and from registered state otherwise.
REQ-022 Load accepted in cycle N: mem_re=1, mem_addr=alu_result in N; wb_valid=1, wb_data=mem_rdata in N+1; state stays IDLE.
REQ-023 Store accepted in N: mem_we=1, mem_addr=alu_result, mem_wdata=write_data in N; no writeback.
REQ-024 Push accepted in N: write write_data at SP in N; SP becomes SP-1 at end of N.
REQ-025 Pop accepted in N: mem_re at SP+1 in N; SP becomes SP+1 at end of N; wb_valid with mem_rdata in N+1.
REQ-026 Push2 accepted in N: write ctx_in[31:16] at SP in N; latch ctx_in[15:0]; go to PUSH2_LO.
REQ-027 Push2 continued in N+1 (PUSH2_LO): write the latched low word at SP-1; SP becomes SP-2; return to IDLE.
REQ-028 Pop2 accepted in N: mem_re at SP+1 in N; go to POP2_HI.
REQ-029 Pop2 in N+1 (POP2_HI): latch mem_rdata as the low word; mem_re at SP+2; SP becomes SP+2; return to IDLE.
REQ-030 Pop2 completion in N+2: ctx_valid=1, ctx_out={mem_rdata, latched low}.
REQ-031 A new operation MAY be accepted in N+2 of pop2 and in N+2 of push2; back-to-back single-word operations SHALL be accepted every cycle.
REQ-032 All SP and address arithmetic SHALL be modulo 2^16; SP wraps 0000->FFFF on push and FFFF->0000 on pop with no error indication.
REQ-033 op=000 or op=111, or ex_valid=0, SHALL produce no memory strobe and no SP change.
REQ-034 Inputs presented while in_ready=0 SHALL be ignored; upstream holds them.
REQ-035 wb_valid and ctx_valid SHALL never be asserted in the same cycle; mem_we and mem_re SHALL never both be 1.
REQ-036 sp_out SHALL reflect the registered SP, updated at the clock edge that ends the relevant cycle.

Reset
REQ-037 While reset=1 at a rising edge: state=IDLE, SP=SP_INIT, wb_valid=0, ctx_valid=0, wb_data=0, ctx_out=0, latched words=0.
REQ-038 mem_we and mem_re SHALL be 0 in any cycle with reset=1, regardless of ex_valid.
REQ-039 Reset during PUSH2_LO or POP2_HI SHALL abort the operation; the pending low-word write and the ctx_valid pulse SHALL NOT occur.

Verification
REQ-040 Reset, then push 16'h1234 then pop -> write at FFFF, sp_out FFFE; then read at FFFF, wb_data 16'h1234, sp_out FFFF.
REQ-041 Push2 ctx_in=32'hAABB_CCDD at SP=FFFF -> FFFF=AABB, FFFE=CCDD, in_ready=0 for one cycle, sp_out FFFD; then pop2 -> ctx_valid with ctx_out 32'hAABB_CCDD two cycles later, sp_out FFFF.
REQ-042 Store 16'h00FF at 0x0010, then load 0x0010 in the next cycle -> wb_valid one cycle after the load, wb_data 16'h00FF, in_ready=1 throughout.
REQ-043 SP=0000, push 16'h5555 -> write at 0000, sp_out FFFF; then pop at SP=FFFF -> read at 0000, sp_out 0000.
REQ-044 Assert reset in POP2_HI -> no ctx_valid, sp_out=SP_INIT, no strobes in the reset cycle.
REQ-045 op=111 with ex_valid=1 -> no strobes, SP unchanged, in_ready stays 1.
